// File: rtl/mat_mult_stream_pkg.sv
// Shared types and sizing helpers for the streaming 3x3 matrix multiplier.
package mat_pkg;

    localparam int DEF_DW = 8;
    localparam int DEF_N  = 3;

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        COMPUTE,
        DRAIN
    } state_t;

    // Width of a linear element index into an n x n matrix (never zero).
    function automatic int idx_width(input int n);
        return (n * n > 1) ? $clog2(n * n) : 1;
    endfunction

    // Width of a row/column/inner-product counter for dimension n (never zero).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDXW = idx_width(DEF_N);

endpackage

// File: rtl/mat_mult_stream_if.sv
// Element-stream handshake bundle: input stream, result stream and status.
interface mat_mult_stream_if
    import mat_pkg::*;
#(
    parameter int DW = DEF_DW
);

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, busy
    );

endinterface

// File: rtl/mat_mult_stream_mac.sv
// Single multiply-accumulate lane; everything wraps modulo 2^DW.
// sum is the value the accumulator takes on this edge, so callers can
// capture a finished dot product in the same cycle as its last term.
module mat_mac
    import mat_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clear,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] sum
);

    logic [DW-1:0] acc;
    logic [DW-1:0] prod;

    // Truncated product plus either a fresh zero or the running total.
    always_comb begin
        prod = a * b;
        sum  = (clear ? '0 : acc) + prod;
    end

    // Accumulator advances only while the owner is stepping through terms.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/mat_mult_stream.sv
// Streaming front-end for an NxN matrix multiply: loads A then B row-major,
// walks i/j/k through one shared MAC, then streams Res out row-major.
module mat_mult_stream
    import mat_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int N  = DEF_N
) (
    input  logic               clk,
    input  logic               rst,
    mat_mult_stream_if.slave   bus
);

    localparam int NN = N * N;
    localparam int IW = (N == DEF_N) ? IDXW : idx_width(N);
    localparam int CW = cnt_width(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    state_t        state;
    state_t        state_nx;
    logic [IW-1:0] idx;
    logic [IW-1:0] oidx;
    logic [CW-1:0] ci;
    logic [CW-1:0] cj;
    logic [CW-1:0] ck;

    logic [DW-1:0] a_mem   [NN];
    logic [DW-1:0] b_mem   [NN];
    logic [DW-1:0] res_mem [NN];

    logic          in_ready_q;
    logic          out_valid_q;
    logic [DW-1:0] out_data_q;
    logic          out_last_q;
    logic          busy_q;

    logic          in_beat;
    logic          out_beat;
    logic          mac_last;
    logic          mac_en;
    logic          mac_clear;
    logic          res_we;
    logic          load_out;
    logic          fwd;
    logic [IW-1:0] a_addr;
    logic [IW-1:0] b_addr;
    logic [IW-1:0] res_addr;
    logic [IW-1:0] rd_addr;
    logic [DW-1:0] mac_sum;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = busy_q;

    // Handshake beats and the operand/result addresses for the current i,j,k.
    always_comb begin
        in_beat   = bus.in_valid && in_ready_q;
        out_beat  = out_valid_q && bus.out_ready;
        mac_last  = (ci == LAST_CNT) && (cj == LAST_CNT) && (ck == LAST_CNT);
        mac_en    = (state == COMPUTE);
        mac_clear = (ck == '0);
        res_we    = (state == COMPUTE) && (ck == LAST_CNT);
        a_addr    = IW'(int'(ci) * N + int'(ck));
        b_addr    = IW'(int'(ck) * N + int'(cj));
        res_addr  = IW'(int'(ci) * N + int'(cj));
    end

    // Sequencing: two loads, N^3 MAC steps, then drain until the last beat.
    always_comb begin
        state_nx = state;
        case (state)
            LOAD_A:  if (in_beat && idx == LAST_IDX)   state_nx = LOAD_B;
            LOAD_B:  if (in_beat && idx == LAST_IDX)   state_nx = COMPUTE;
            COMPUTE: if (mac_last)                     state_nx = DRAIN;
            DRAIN:   if (out_beat && oidx == LAST_IDX) state_nx = LOAD_A;
            default: state_nx = LOAD_A;
        endcase
    end

    // Choose which result element the output register should pick up next;
    // a result being written this very edge is forwarded straight from the MAC.
    always_comb begin
        load_out = 1'b0;
        rd_addr  = '0;
        if (state == COMPUTE && mac_last) begin
            load_out = 1'b1;
            rd_addr  = '0;
        end else if (state == DRAIN && out_beat && oidx != LAST_IDX) begin
            load_out = 1'b1;
            rd_addr  = oidx + IW'(1);
        end
        fwd = res_we && (res_addr == rd_addr);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD_A;
        end else begin
            state <= state_nx;
        end
    end

    // Capture incoming A and B elements; idx wraps between the two matrices.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
            for (int n = 0; n < NN; n++) begin
                a_mem[n] <= '0;
                b_mem[n] <= '0;
            end
        end else if (in_beat) begin
            if (state == LOAD_A) begin
                a_mem[idx] <= bus.in_data;
            end else if (state == LOAD_B) begin
                b_mem[idx] <= bus.in_data;
            end
            idx <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
        end
    end

    // i/j/k nest with k innermost; all three return to zero after the last step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ci <= '0;
            cj <= '0;
            ck <= '0;
        end else if (state == COMPUTE) begin
            if (ck == LAST_CNT) begin
                ck <= '0;
                if (cj == LAST_CNT) begin
                    cj <= '0;
                    ci <= (ci == LAST_CNT) ? '0 : ci + CW'(1);
                end else begin
                    cj <= cj + CW'(1);
                end
            end else begin
                ck <= ck + CW'(1);
            end
        end
    end

    // Store each finished dot product into the result matrix.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < NN; n++) begin
                res_mem[n] <= '0;
            end
        end else if (res_we) begin
            res_mem[res_addr] <= mac_sum;
        end
    end

    // Output element pointer advances only on accepted result beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oidx <= '0;
        end else if (out_beat) begin
            oidx <= (oidx == LAST_IDX) ? '0 : oidx + IW'(1);
        end
    end

    // Registered outputs, all derived from the upcoming state so nothing is
    // combinational from the inputs; data holds while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            in_ready_q  <= (state_nx == LOAD_A) || (state_nx == LOAD_B);
            out_valid_q <= (state_nx == DRAIN);
            busy_q      <= (state_nx != LOAD_A) || (idx != '0) || in_beat;
            if (load_out) begin
                out_data_q <= fwd ? mac_sum : res_mem[rd_addr];
                out_last_q <= (rd_addr == LAST_IDX);
            end else if (state_nx != DRAIN) begin
                out_data_q <= '0;
                out_last_q <= 1'b0;
            end
        end
    end

    mat_mac #(
        .DW (DW)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .en    (mac_en),
        .clear (mac_clear),
        .a     (a_mem[a_addr]),
        .b     (b_mem[b_addr]),
        .sum   (mac_sum)
    );

endmodule

// File: tb/tb_mat_mult_stream.sv
// Self-checking bench for mat_mult_stream: fixed scenarios plus randomized
// jobs compared against a plain-arithmetic matrix product.
module tb_mat_mult_stream;

    typedef logic [7:0] mat_t [9];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared   = 0;
    int   mismatched = 0;

    mat_t a1 = '{8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd4, 8'd4, 8'd5};
    mat_t b1 = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    mat_t e1 = '{8'd21, 8'd17, 8'd13, 8'd45, 8'd37, 8'd29, 8'd75, 8'd62, 8'd49};
    mat_t a10 = '{default: 8'd10};
    mat_t e44 = '{default: 8'd44};
    mat_t ident = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};

    mat_mult_stream_if bus ();

    mat_mult_stream dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference product: plain sum of products, reduced modulo 256.
    function automatic void ref_mult(input mat_t a, input mat_t b, output mat_t r);
        int s;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                s = 0;
                for (int k = 0; k < 3; k++) begin
                    s += int'(a[i*3+k]) * int'(b[k*3+j]);
                end
                r[i*3+j] = 8'(s % 256);
            end
        end
    endfunction

    // Present one element and hold it until accepted; returns at the negedge after the beat.
    task automatic push(input logic [7:0] d);
        int w;
        w = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (bus.in_ready !== 1'b1 && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (w >= 300) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL push_timeout: in_ready=%b required 1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_job(input mat_t a, input mat_t b, input int max_gap);
        int gap;
        for (int n = 0; n < 18; n++) begin
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (gap) @(negedge clk);
            push(n < 9 ? a[n] : b[n-9]);
        end
    endtask

    // Count cycles from the last B beat until out_valid; in_ready must stay low meanwhile.
    task automatic wait_result(input bit check_lat, input bit hold_junk, input string tag);
        int lat;
        lat = 0;
        if (hold_junk) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'hEE;
        end
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            compared++;
            if (bus.in_ready !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL %s_in_ready_compute: got %b required 0", tag, bus.in_ready);
            end
            @(negedge clk);
            lat++;
        end
        if (hold_junk) bus.in_valid = 1'b0;
        if (lat >= 200) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s_result_timeout: out_valid=%b required 1", tag, bus.out_valid);
        end else if (check_lat) begin
            compared++;
            if (lat != 27) begin
                mismatched++;
                $display("[TB] FAIL %s_latency: got %0d required 27", tag, lat);
            end
        end
    endtask

    // Drain nine results; mode 0 always ready, 1 ready pattern 1-0-0-1, 2 random.
    task automatic drain(input mat_t exp, input int mode, input string tag);
        int e;
        int cyc;
        logic rdy;
        e = 0;
        cyc = 0;
        while (e < 9 && cyc < 500) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = 1'($urandom_range(1, 0));
            endcase
            bus.out_ready = rdy;
            compared++;
            if (bus.out_valid !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL %s_out_valid[%0d]: got %b required 1", tag, e, bus.out_valid);
            end
            compared++;
            if (bus.out_data !== exp[e]) begin
                mismatched++;
                $display("[TB] FAIL %s_data[%0d]: got %0d required %0d", tag, e, bus.out_data, exp[e]);
            end
            compared++;
            if (bus.out_last !== (e == 8)) begin
                mismatched++;
                $display("[TB] FAIL %s_last[%0d]: got %b required %b", tag, e, bus.out_last, (e == 8));
            end
            compared++;
            if (bus.in_ready !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL %s_in_ready_drain[%0d]: got %b required 0", tag, e, bus.in_ready);
            end
            compared++;
            if (bus.busy !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL %s_busy_drain[%0d]: got %b required 1", tag, e, bus.busy);
            end
            if (rdy) e++;
            @(negedge clk);
            cyc++;
        end
        bus.out_ready = 1'b0;
        if (e < 9) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s_drain_timeout: got %0d beats required 9", tag, e);
        end
        compared++;
        if (bus.out_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL %s_out_valid_after: got %b required 0", tag, bus.out_valid);
        end
        compared++;
        if (bus.in_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL %s_in_ready_after: got %b required 1", tag, bus.in_ready);
        end
        compared++;
        if (bus.busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL %s_busy_after: got %b required 0", tag, bus.busy);
        end
    endtask

    task automatic check_idle(input string tag);
        compared++;
        if (bus.in_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL %s_in_ready: got %b required 1", tag, bus.in_ready);
        end
        compared++;
        if (bus.out_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL %s_out_valid: got %b required 0", tag, bus.out_valid);
        end
        compared++;
        if (bus.out_data !== 8'd0) begin
            mismatched++;
            $display("[TB] FAIL %s_out_data: got %0d required 0", tag, bus.out_data);
        end
        compared++;
        if (bus.out_last !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL %s_out_last: got %b required 0", tag, bus.out_last);
        end
        compared++;
        if (bus.busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL %s_busy: got %b required 0", tag, bus.busy);
        end
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'd0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("reset");
    endtask

    task automatic test_basic();
        send_job(a1, b1, 0);
        wait_result(1'b1, 1'b0, "basic");
        drain(e1, 0, "basic");
    endtask

    task automatic test_wrap();
        send_job(a10, a10, 0);
        wait_result(1'b1, 1'b0, "wrap");
        drain(e44, 0, "wrap");
    endtask

    task automatic test_stall();
        send_job(a1, b1, 0);
        wait_result(1'b1, 1'b0, "stall");
        drain(e1, 1, "stall");
    endtask

    task automatic test_gaps();
        send_job(a1, b1, 3);
        wait_result(1'b1, 1'b1, "gaps");
        drain(e1, 0, "gaps");
    endtask

    task automatic test_mid_reset();
        for (int n = 0; n < 5; n++) push(8'($urandom_range(255, 0)));
        compared++;
        if (bus.busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL midrst_busy_before: got %b required 1", bus.busy);
        end
        rst = 1'b1;
        #2;
        check_idle("midrst_async");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_job(a1, b1, 0);
        wait_result(1'b1, 1'b0, "midrst");
        drain(e1, 0, "midrst");
    endtask

    task automatic test_back_to_back();
        send_job(a1, b1, 0);
        fork
            begin
                wait_result(1'b1, 1'b0, "b2b_job1");
                drain(e1, 0, "b2b_job1");
            end
            begin
                send_job(ident, b1, 0);
            end
        join
        wait_result(1'b1, 1'b0, "b2b_job2");
        drain(b1, 0, "b2b_job2");
    endtask

    task automatic test_random();
        mat_t a;
        mat_t b;
        mat_t r;
        for (int job = 0; job < 4; job++) begin
            for (int n = 0; n < 9; n++) begin
                a[n] = 8'($urandom_range(255, 0));
                b[n] = 8'($urandom_range(255, 0));
            end
            ref_mult(a, b, r);
            bus.out_ready = 1'($urandom_range(1, 0));
            send_job(a, b, 2);
            wait_result(1'b1, 1'b0, "random");
            drain(r, 2, "random");
        end
    endtask

    // Hard stop in case something upstream of the bounded waits wedges.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scenario sequence.
    initial begin
        $display("[TB] starting mat_mult_stream bench");
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_gaps();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
